bresenham_line_tracer: RTL
==========================

// Module: bresenham_line_tracer
// PURPOSE
//  Responder side of the bresenham_start/bresenham_busy handshake driven by the SLAM control unit.
//  Accepts one ray per start pulse: robot cell (x0,y0) to scan endpoint cell (x1,y1).
//  Emits every grid cell on the ray, in order, over a valid/ready stream to the occupancy grid updater.
//  Cells before the endpoint are tagged free (cell_hit=0); the endpoint is tagged occupied (cell_hit=1).
// PARAMETERS
//  COORD_W   12   signed coordinate width of x0/y0/x1/y1, in cells
//  GRID_X    256  grid width in cells; legal x is 0..GRID_X-1
//  GRID_Y    256  grid height in cells; legal y is 0..GRID_Y-1
//  IDX_W     8    cell index width; equals $clog2(max(GRID_X,GRID_Y))
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  start       in   1        one-cycle request; sampled only in IDLE
//  x0,y0       in   COORD_W  signed ray origin, latched on accepted start
//  x1,y1       in   COORD_W  signed ray end, latched on accepted start
//  busy        out  1        high in every state except IDLE
//  cell_valid  out  1        cell_x/cell_y/cell_hit hold an in-grid cell
//  cell_ready  in   1        downstream accepts the cell this cycle
//  cell_x      out  IDX_W    cell column index
//  cell_y      out  IDX_W    cell row index
//  cell_hit    out  1        1 only on the endpoint cell
// BEHAVIOUR
//  Reset: state=IDLE; busy, cell_valid, cell_hit=0; cell_x, cell_y=0; all internal registers cleared.
//  Reset mid-ray aborts the ray immediately. No cell is emitted after reset.
//  IDLE: busy=0. If start=1, latch the four coordinates and go to SETUP. Otherwise stay in IDLE.
//  SETUP (1 cycle):
//   - dx=|x1-x0| and dy=-|y1-y0|, each COORD_W+1 bits signed.
//   - sx=+1 if x1>x0, else -1. sy=+1 if y1>y0, else -1.
//   - err=dx+dy, COORD_W+2 bits signed.
//   - (cx,cy)=(x0,y0). Go to EMIT.
//  EMIT: present (cx,cy). inb = 0<=cx<GRID_X and 0<=cy<GRID_Y.
//   - cell_valid=inb. cell_hit = (cx==x1 && cy==y1).
//   - cell_x/cell_y = low IDX_W bits of cx/cy. These are held stable while cell_valid && !cell_ready.
//  Advance condition: (cell_valid && cell_ready) || !inb.
//   - Out-of-grid cells are skipped at 1 cycle each and never emitted.
//   - On advance at the endpoint: go to IDLE; busy=0 on the next cycle.
//   - On any other advance: e2=2*err. If e2>=dy: err+=dy, cx+=sx. If e2<=dx: err+=dx, cy+=sy.
//   - Both updates use the pre-update err and may fire in the same cycle (diagonal step).
//  Timing:
//   - start sampled at edge k; busy=1 from cycle k+1 (SETUP); first cell presented in cycle k+2.
//   - Throughput is 1 cell/cycle with cell_ready held high.
//   - Cell count = max(|x1-x0|,|y1-y0|)+1 minus the skipped out-of-grid cells.
//  Boundary conditions:
//   - start while busy: ignored; the latched ray is unaffected.
//   - Zero-length ray (x0==x1, y0==y1): exactly one cell, with cell_hit=1.
//   - Endpoint out of grid: no hit is emitted; the ray still ends and busy drops.
//   - The control unit checks busy in the cycle after start. busy must therefore come straight from state and never depend on start.
//   - cell_ready is ignored while cell_valid=0.
// STRUCTURE
//  Shared package hector_pkg:
//   - coord_t (signed COORD_W), cell_idx_t (IDX_W).
//   - tracer_state_t enum {IDLE, SETUP, EMIT}.
//   - Functions abs_coord() and sign_step().
//  No sub-module. The block is a single FSM plus a step datapath.
//  The step datapath (e2 compare, err/cx/cy update) sits in one always_comb block feeding the registers.
// TESTING
//  1. (0,0)->(5,2), ready=1: cells (0,0)(1,0)(2,1)(3,1)(4,2)(5,2) on consecutive cycles; hit only on (5,2); busy low 1 cycle later.
//  2. (3,3)->(3,3): one cell (3,3) with hit=1; busy high for exactly 2 cycles (SETUP, EMIT).
//  3. (2,7)->(-2,3) with GRID 256: cells (2,7)(1,6)(0,5) are emitted; x<0 cells are skipped silently; no hit; busy then falls.
//  4. (0,0)->(0,4) with ready low for 3 cycles on (0,2): outputs held stable, no cell lost or duplicated; 5 cells total.
//  5. start pulsed again on cell 2 of (0,0)->(6,0): ignored; 7 cells emitted from the original ray.
//  6. reset asserted during EMIT of (10,10)->(40,20): next cycle busy=0 and cell_valid=0; a new start runs a clean ray.

Source files
------------

// File: rtl/hector_pkg.sv
// Shared types, grid geometry and small helpers for the SLAM ray tracer.
package hector_pkg;

  localparam int COORD_W = 12;
  localparam int GRID_X  = 256;
  localparam int GRID_Y  = 256;
  localparam int IDX_W   = 8;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic        [IDX_W-1:0]   cell_idx_t;
  typedef logic signed [COORD_W:0]   delta_t;
  typedef logic signed [COORD_W+1:0] err_t;
  typedef logic signed [1:0]         step_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } tracer_state_t;

  function automatic delta_t abs_coord(input delta_t d);
    return (d < 0) ? -d : d;
  endfunction

  // +1 when the ray moves towards larger coordinates, otherwise -1.
  function automatic step_t sign_step(input coord_t from_c, input coord_t to_c);
    return (to_c > from_c) ? 2'sd1 : -2'sd1;
  endfunction

endpackage

// File: rtl/bresenham_line_tracer_if.sv
// Start/busy request handshake plus the valid/ready cell stream of the ray tracer.
// Stream: a cell transfers on a rising edge where cell_valid && cell_ready; the cell is held stable until then.
interface bresenham_line_tracer_if;
  import hector_pkg::*;

  logic      start;
  coord_t    x0;
  coord_t    y0;
  coord_t    x1;
  coord_t    y1;
  logic      busy;
  logic      cell_valid;
  logic      cell_ready;
  cell_idx_t cell_x;
  cell_idx_t cell_y;
  logic      cell_hit;

  modport master (
    output start, x0, y0, x1, y1, cell_ready,
    input  busy, cell_valid, cell_x, cell_y, cell_hit
  );

  modport slave (
    input  start, x0, y0, x1, y1, cell_ready,
    output busy, cell_valid, cell_x, cell_y, cell_hit
  );

endinterface

// File: rtl/bresenham_line_tracer.sv
// Walks one Bresenham ray per start, streaming each in-grid cell; the endpoint is tagged as a hit.
module bresenham_line_tracer
  import hector_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  bresenham_line_tracer_if.slave bus,
  output tracer_state_t       state_o
);

  tracer_state_t state_q, state_d;
  coord_t        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  coord_t        cx_q, cx_d, cy_q, cy_d;
  delta_t        dx_q, dx_d, dy_q, dy_d;
  step_t         sx_q, sx_d, sy_q, sy_d;
  err_t          err_q, err_d;

  logic                     emit;
  logic                     inb;
  logic                     at_end;
  logic                     advance;
  logic signed [COORD_W+2:0] e2;

  localparam coord_t GRID_X_C = coord_t'(GRID_X);
  localparam coord_t GRID_Y_C = coord_t'(GRID_Y);

  assign emit    = (state_q == EMIT);
  assign inb     = !cx_q[COORD_W-1] && (cx_q < GRID_X_C) && !cy_q[COORD_W-1] && (cy_q < GRID_Y_C);
  assign at_end  = (cx_q == x1_q) && (cy_q == y1_q);
  // Off-grid cells are never offered downstream, so they step through unconditionally.
  assign advance = emit && ((inb && bus.cell_ready) || !inb);
  assign e2      = {err_q[COORD_W+1], err_q, 1'b0};

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d    = abs_coord(delta_t'(x1_q) - delta_t'(x0_q));
        dy_d    = -abs_coord(delta_t'(y1_q) - delta_t'(y0_q));
        sx_d    = sign_step(x0_q, x1_q);
        sy_d    = sign_step(y0_q, y1_q);
        err_d   = err_t'(dx_d) + err_t'(dy_d);
        cx_d    = x0_q;
        cy_d    = y0_q;
        state_d = EMIT;
      end
      EMIT: begin
        if (advance) begin
          if (at_end) begin
            state_d = IDLE;
          end else begin
            // Both tests use the pre-step error so a diagonal move updates x and y together.
            if (e2 >= dy_q) begin
              err_d = err_d + err_t'(dy_q);
              cx_d  = cx_q + coord_t'(sx_q);
            end
            if (e2 <= dx_q) begin
              err_d = err_d + err_t'(dx_q);
              cy_d  = cy_q + coord_t'(sy_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.cell_valid = emit && inb;
  assign bus.cell_hit   = emit && inb && at_end;
  assign bus.cell_x     = cell_idx_t'(cx_q);
  assign bus.cell_y     = cell_idx_t'(cy_q);
  assign state_o        = state_q;

endmodule
